// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// MEM stage of the 16-bit pipelined CPU. Consumes the EX/MEM register outputs,
// performs loads/stores against data memory over a req/ack handshake with
// variable latency, stalls the upstream pipeline while an access is
// outstanding, and drives registered results toward the MEM/WB register.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   When defined, a WAIT-cycle counter aborts an access that has gone
//   TIMEOUT_CYCLES cycles without mem_ack and pulses mem_err_out.
//   When undefined, WAIT is unbounded and mem_err_out is tied 0.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   valid_in, flush_in    live instruction / kill current or incoming one
//   wbs_in, mm_in, wm_in  writeback enable, load select, store select
//   ni_in, wme_in         pass-through control flags
//   alu_result_in         ALU result, also the memory word address
//   mem_data_in           store data
//   reg_dest_in           destination register
//   stall_out             hold EX/MEM and earlier stages (combinational)
//   mem_req/we/addr/wdata memory request side
//   mem_rdata, mem_ack    memory response side
//   valid_out, wbs_out, ni_out, wme_out, wb_data_out, reg_dest_out
//                         registered results toward MEM/WB
//   mem_err_out           one-cycle pulse on a timeout abort
//
// Memory handshake: mem_req rises on the edge that enters WAIT and stays high,
// with mem_we/mem_addr/mem_wdata stable, until the edge on which mem_ack is
// sampled high. mem_ack is a one-cycle pulse, and mem_rdata is valid in that
// same cycle. An ack seen while no request is outstanding is ignored.
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              flush_in,
    input  logic              wbs_in,
    input  logic              mm_in,
    input  logic              wm_in,
    input  logic              ni_in,
    input  logic              wme_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic [4:0]        reg_dest_in,
    output logic              stall_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              valid_out,
    output logic              wbs_out,
    output logic              ni_out,
    output logic              wme_out,
    output logic [DATA_W-1:0] wb_data_out,
    output logic [4:0]        reg_dest_out,
    output logic              mem_err_out
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t state;

    // Instruction context held while the access is outstanding.
    logic              kill;
    logic              mm_q;
    logic              wbs_q;
    logic              ni_q;
    logic              wme_q;
    logic [4:0]        dest_q;
    logic [DATA_W-1:0] alu_q;

    logic mem_op;
    logic timeout_hit;

    // A flushed instruction never starts an access.
    assign mem_op = valid_in & ~flush_in & (mm_in | wm_in);

    // In IDLE the stall covers the cycle that launches the access, so the
    // instruction stays in EX/MEM until the access completes. It drops on the
    // completing cycle (ack or abort) so upstream advances on that edge.
    assign stall_out = rst_n & ((state == S_IDLE) ? mem_op : ~(mem_ack | timeout_hit));

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : CNT_RAW;

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    // wait_cnt counts completed WAIT cycles, so it equals TIMEOUT_CYCLES-1
    // during the TIMEOUT_CYCLES-th WAIT cycle. An ack in that cycle wins.
    assign timeout_hit = (state == S_WAIT) & ~mem_ack &
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= timeout_hit;
            if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    assign mem_err_out = err_q;
`else
    assign timeout_hit = 1'b0;
    assign mem_err_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            kill         <= 1'b0;
            mm_q         <= 1'b0;
            wbs_q        <= 1'b0;
            ni_q         <= 1'b0;
            wme_q        <= 1'b0;
            dest_q       <= '0;
            alu_q        <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            valid_out    <= 1'b0;
            wbs_out      <= 1'b0;
            ni_out       <= 1'b0;
            wme_out      <= 1'b0;
            wb_data_out  <= '0;
            reg_dest_out <= '0;
        end else begin
            // valid_out is a one-cycle pulse per retired instruction.
            valid_out <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (valid_in && !flush_in) begin
                        if (mm_in || wm_in) begin
                            state     <= S_WAIT;
                            mem_req   <= 1'b1;
                            mem_we    <= wm_in;
                            mem_addr  <= alu_result_in[ADDR_W-1:0];
                            mem_wdata <= mem_data_in;
                            // mm together with wm is a store: keep the ALU result.
                            mm_q      <= mm_in & ~wm_in;
                            wbs_q     <= wbs_in;
                            ni_q      <= ni_in;
                            wme_q     <= wme_in;
                            dest_q    <= reg_dest_in;
                            alu_q     <= alu_result_in;
                            kill      <= 1'b0;
                        end else begin
                            valid_out    <= 1'b1;
                            wbs_out      <= wbs_in;
                            ni_out       <= ni_in;
                            wme_out      <= wme_in;
                            wb_data_out  <= alu_result_in;
                            reg_dest_out <= reg_dest_in;
                        end
                    end
                end

                S_WAIT: begin
                    // A flush cannot cancel the handshake; it only turns the
                    // eventual result into a bubble.
                    if (flush_in) begin
                        kill <= 1'b1;
                    end

                    if (mem_ack) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                        kill    <= 1'b0;
                        if (!(kill || flush_in)) begin
                            valid_out    <= 1'b1;
                            wbs_out      <= wbs_q;
                            ni_out       <= ni_q;
                            wme_out      <= wme_q;
                            wb_data_out  <= mm_q ? mem_rdata : alu_q;
                            reg_dest_out <= dest_q;
                        end
                    end else if (timeout_hit) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                        kill    <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
`timescale 1ns/1ps
module tb_mem_access_stage;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int W      = 24;  // {wbs, ni, wme, dest[4:0], data[15:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              valid_in = 0, flush_in = 0, wbs_in = 0, mm_in = 0, wm_in = 0;
  logic              ni_in = 0, wme_in = 0;
  logic [DATA_W-1:0] alu_result_in = '0, mem_data_in = '0;
  logic [4:0]        reg_dest_in = '0;
  logic              stall_out, mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ack = 1'b0;
  logic              valid_out, wbs_out, ni_out, wme_out, mem_err_out;
  logic [DATA_W-1:0] wb_data_out;
  logic [4:0]        reg_dest_out;

  mem_access_stage #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .flush_in(flush_in),
    .wbs_in(wbs_in), .mm_in(mm_in), .wm_in(wm_in), .ni_in(ni_in), .wme_in(wme_in),
    .alu_result_in(alu_result_in), .mem_data_in(mem_data_in), .reg_dest_in(reg_dest_in),
    .stall_out(stall_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .valid_out(valid_out), .wbs_out(wbs_out), .ni_out(ni_out), .wme_out(wme_out),
    .wb_data_out(wb_data_out), .reg_dest_out(reg_dest_out), .mem_err_out(mem_err_out)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0]  exp_q[$];   // expected retired results, in order
  logic [32:0]   req_q[$];   // expected memory requests {we, addr, wdata}
  logic [15:0]   ref_mem[int];
  logic [15:0]   dut_mem[int];

  bit   resp_en = 1'b1;
  int   fixed_delay = -1;
  int   last_req_cnt = 0;
  bit   man_ack = 1'b0;
  logic [15:0] man_rdata = '0;
  bit   allow_err = 1'b0;
  int   cyc = 0, valid_cnt = 0, last_valid_cyc = -10, prev_valid_cyc = -10;

  // Background contents of data memory before any store.
  function automatic logic [15:0] init_word(input logic [15:0] a);
    return (a * 16'd40503) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {mem_req, mem_we, valid_out, wbs_out, ni_out, wme_out, mem_err_out, stall_out}, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_wb_data"}, wb_data_out, 0);
    chk({tag, "_reg_dest"}, reg_dest_out, 0);
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // ---------------- driver ----------------
  // Presents one instruction and holds it until the stage accepts it (stall
  // low). The reference model decides the outcome from the instruction-level
  // rules: ALU op -> ALU result; load -> memory word; store (incl. mm+wm) ->
  // memory updated, ALU result written back; any flush -> no result.
  task automatic run_instr(input bit v, input bit mm, input bit wm, input bit wbs,
                           input bit ni, input bit wme, input logic [15:0] alu,
                           input logic [15:0] wd, input logic [4:0] dest,
                           input bit fl_now, input int fl_wait, output int waited);
    bit killed;
    logic [W-1:0] item;
    @(negedge clk);
    valid_in = v; mm_in = mm; wm_in = wm; wbs_in = wbs; ni_in = ni; wme_in = wme;
    alu_result_in = alu; mem_data_in = wd; reg_dest_in = dest; flush_in = fl_now;
    killed = 1'b0;
    item = '0;
    if (v && !fl_now) begin
      if (mm || wm) begin
        req_q.push_back({wm, alu, wd});
        if (wm) begin
          ref_mem[int'(alu)] = wd;
          item = {wbs, ni, wme, dest, alu};
        end else begin
          item = {wbs, ni, wme, dest, ref_read(alu)};
        end
      end else begin
        item = {wbs, ni, wme, dest, alu};
      end
    end
    waited = 0;
    forever begin
      #3;
      if (!stall_out) break;
      if (waited >= 50) begin
        checks++; errors++;
        $display("FAIL accept_bound: stalled %0d cycles, required below 50", waited);
        finish_sim();
      end
      @(negedge clk);
      waited++;
      flush_in = (waited == fl_wait);
      if (flush_in) killed = 1'b1;
    end
    if (v && !fl_now && !killed) exp_q.push_back(item);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    valid_in = 0; flush_in = 0; mm_in = 0; wm_in = 0;
    repeat (n - 1) @(negedge clk);
  endtask

  // ---------------- memory responder ----------------
  initial begin : responder
    bit busy;
    int left, cnt;
    logic [32:0] r;
    busy = 0; left = 0; cnt = 0;
    forever begin
      @(negedge clk);
      if (resp_en) begin
        mem_ack = 1'b0;
        if (mem_req) begin
          if (!busy) begin
            busy = 1; cnt = 0;
            left = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
          end
          cnt++;
          if (left == 0) begin
            mem_ack = 1'b1;
            busy = 0;
            last_req_cnt = cnt;
            if (req_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_req: we=%0b addr=%0h with no request outstanding", mem_we, mem_addr);
            end else begin
              r = req_q.pop_front();
              chk("mem_request", {mem_we, mem_addr, mem_wdata}, r);
            end
            if (mem_we) begin
              dut_mem[int'(mem_addr)] = mem_wdata;
              mem_rdata = 16'($urandom);
            end else begin
              mem_rdata = dut_mem.exists(int'(mem_addr)) ? dut_mem[int'(mem_addr)] : init_word(mem_addr);
            end
          end else begin
            left--;
          end
        end
      end else begin
        busy = 0;
        mem_ack = man_ack;
        mem_rdata = man_rdata;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [W-1:0] item;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (valid_out) begin
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
        valid_cnt++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: valid_out=1 dest=%0d data=%0h with no result outstanding",
                   reg_dest_out, wb_data_out);
        end else begin
          item = exp_q.pop_front();
          chk("wb_result", {wbs_out, ni_out, wme_out, reg_dest_out, wb_data_out}, item);
        end
      end
      if (mem_err_out && !allow_err) begin
        checks++; errors++;
        $display("FAIL unexpected_err: mem_err_out=1 required 0");
      end
    end
  end

  initial begin : watchdog
    #300000;
    checks++; errors++;
    $display("FAIL watchdog: time limit reached before end of test");
    finish_sim();
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int w, op, vc;
    // Reset, with a load presented: everything including stall must be 0.
    #12;
    valid_in = 1; mm_in = 1; alu_result_in = 16'h0040; reg_dest_in = 5'd7; wbs_in = 1;
    #1;
    chk_zero("reset_init");
    valid_in = 0; mm_in = 0; wbs_in = 0; alu_result_in = '0; reg_dest_in = '0;
    @(negedge clk);
    rst_n = 1;
    idle(2);

    // Back-to-back ALU ops: consecutive valid pulses, never a stall.
    run_instr(1, 0, 0, 1, 0, 1, 16'h1234, 16'h0, 5'd3, 0, 0, w);
    chk("alu1_stall", w, 0);
    run_instr(1, 0, 0, 1, 1, 0, 16'hBEEF, 16'h0, 5'd4, 0, 0, w);
    chk("alu2_stall", w, 0);
    idle(3);
    chk("alu_back_to_back", last_valid_cyc - prev_valid_cyc, 1);

    // Load 0x00A0 acked in the 3rd WAIT cycle with 0x5A5A.
    ref_mem[16'h00A0] = 16'h5A5A;
    dut_mem[16'h00A0] = 16'h5A5A;
    fixed_delay = 2;
    run_instr(1, 1, 0, 1, 0, 0, 16'h00A0, 16'h0, 5'd9, 0, 0, w);
    chk("load_stall_cycles", w, 3);
    chk("load_req_cycles", last_req_cnt, 3);
    idle(2);

    // Store 0x0010 <- 0xCAFE acked in the first WAIT cycle, then read it back.
    fixed_delay = 0;
    run_instr(1, 0, 1, 0, 1, 0, 16'h0010, 16'hCAFE, 5'd5, 0, 0, w);
    chk("store_stall_cycles", w, 1);
    run_instr(1, 1, 0, 1, 0, 0, 16'h0010, 16'h0, 5'd6, 0, 0, w);
    idle(2);

    // Load flushed in the 2nd WAIT cycle, ack in the 4th: bubble.
    fixed_delay = 3;
    vc = valid_cnt;
    run_instr(1, 1, 0, 1, 0, 0, 16'h0022, 16'h0, 5'd8, 0, 2, w);
    chk("flush_stall_cycles", w, 4);
    idle(3);
    chk("flush_no_valid", valid_cnt, vc);

    // Flush on the ack cycle itself, and flush of a load in IDLE.
    fixed_delay = 1;
    run_instr(1, 1, 0, 1, 0, 0, 16'h0023, 16'h0, 5'd8, 0, 2, w);
    run_instr(1, 1, 0, 1, 0, 0, 16'h0024, 16'h0, 5'd8, 1, 0, w);
    chk("flush_idle_stall", w, 0);
    idle(3);
    chk("flush_ack_no_valid", valid_cnt, vc);

    // Reset mid-WAIT with a load of 0x0040 pending; a later ack is ignored.
    resp_en = 0;
    @(negedge clk);
    valid_in = 1; mm_in = 1; wm_in = 0; flush_in = 0; alu_result_in = 16'h0040;
    reg_dest_in = 5'd2; wbs_in = 1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_wait_req", {mem_req, mem_we, stall_out}, 3'b101);
    chk("rst_wait_addr", mem_addr, 16'h0040);
    #1 rst_n = 0;
    #1;
    chk_zero("reset_mid_wait");
    valid_in = 0; mm_in = 0;
    @(negedge clk);
    #2 rst_n = 1;
    man_ack = 1; man_rdata = 16'hDEAD;
    @(negedge clk);
    #1 man_ack = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("late_ack_ignored", {valid_out, mem_req}, 2'b00);
    end
    resp_en = 1;
    fixed_delay = -1;
    idle(2);

    // Randomized instruction stream.
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 3);  // 0 ALU, 1 load, 2 store, 3 mm+wm
      run_instr($urandom_range(0, 9) != 0, (op == 1) || (op == 3), op >= 2,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                16'($urandom_range(0, 15)), 16'($urandom), 5'($urandom),
                $urandom_range(0, 9) == 0,
                ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, 4)) : 0, w);
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    idle(8);

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after 4 WAIT cycles with a one-cycle error pulse.
    resp_en = 0;
    allow_err = 1;
    vc = valid_cnt;
    @(negedge clk);
    valid_in = 1; mm_in = 1; wm_in = 0; flush_in = 0; alu_result_in = 16'h0033;
    w = 0;
    forever begin
      #3;
      if (!stall_out || w >= 20) break;
      @(negedge clk);
      w++;
    end
    chk("timeout_stall_cycles", w, 4);
    @(posedge clk);
    #1;
    chk("timeout_err", {mem_err_out, valid_out, mem_req}, 3'b100);
    @(negedge clk);
    valid_in = 0; mm_in = 0;
    #1;
    chk("timeout_stall", stall_out, 0);
    @(posedge clk);
    #1;
    chk("timeout_err_pulse", mem_err_out, 0);
    chk("timeout_no_valid", valid_cnt, vc);
    allow_err = 0;
    resp_en = 1;
    idle(3);
`endif

    chk("exp_q_drained", exp_q.size(), 0);
    chk("req_q_drained", req_q.size(), 0);
    finish_sim();
  end

endmodule
